// File: rtl/wbcon_txarb_if.sv
// Byte-wide AXI-Stream bundle for the TX arbiter: NPORTS source lanes in,
// one merged lane out, plus grant/busy status.
interface wbcon_txarb_if #(
  parameter int NPORTS = 2
);
  logic [NPORTS-1:0]   i_s_axis_tvalid;
  logic [NPORTS-1:0]   o_s_axis_tready;
  logic [8*NPORTS-1:0] i_s_axis_tdata;
  logic [NPORTS-1:0]   i_s_axis_tkeep;
  logic [NPORTS-1:0]   i_s_axis_tlast;
  logic                o_m_axis_tvalid;
  logic                i_m_axis_tready;
  logic [7:0]          o_m_axis_tdata;
  logic                o_m_axis_tkeep;
  logic                o_m_axis_tlast;
  logic [NPORTS-1:0]   o_grant;
  logic                o_busy;

  modport slave (
    input  i_s_axis_tvalid, i_s_axis_tdata, i_s_axis_tkeep, i_s_axis_tlast,
    input  i_m_axis_tready,
    output o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tdata, o_m_axis_tkeep,
    output o_m_axis_tlast, o_grant, o_busy
  );

  modport master (
    output i_s_axis_tvalid, i_s_axis_tdata, i_s_axis_tkeep, i_s_axis_tlast,
    output i_m_axis_tready,
    input  o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tdata, o_m_axis_tkeep,
    input  o_m_axis_tlast, o_grant, o_busy
  );
endinterface

// File: rtl/wbcon_txarb.sv
// Packet-aware round-robin merge of NPORTS byte streams onto the host TX stream.
// state | meaning
// IDLE  | no grant held; arbitrate among requesting ports starting at rr
// PKT   | grant held on gidx until its TLAST beat is accepted
module wbcon_txarb #(
  parameter int NPORTS = 2,
  parameter int PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input logic         i_clk,
  input logic         i_rst,
  wbcon_txarb_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [PTR_W-1:0]  gidx_q, gidx_d;
  logic [PTR_W-1:0]  scan_idx;
  logic              scan_found;
  int                cand;
  int                next_rr;
  logic [NPORTS-1:0] gidx_oh;
  logic [NPORTS-1:0] tready_c;
  logic [NPORTS-1:0] grant_c;
  logic              sel_valid, sel_keep, sel_last;
  logic [7:0]        sel_data;
  logic              out_ready, accept, busy_c;
  logic              m_tvalid_q, m_tkeep_q, m_tlast_q;
  logic [7:0]        m_tdata_q;

  // First requester at or after rr, wrapping modulo NPORTS.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NPORTS; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NPORTS) cand = cand - NPORTS;
      for (int p = 0; p < NPORTS; p++) begin
        if (!scan_found && cand == p && bus.i_s_axis_tvalid[p]) begin
          scan_found = 1'b1;
          scan_idx   = PTR_W'(p);
        end
      end
    end
  end

  always_comb begin
    gidx_oh   = '0;
    sel_valid = 1'b0;
    sel_keep  = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gidx_q == PTR_W'(p)) begin
        gidx_oh[p] = 1'b1;
        sel_valid  = bus.i_s_axis_tvalid[p];
        sel_keep   = bus.i_s_axis_tkeep[p];
        sel_last   = bus.i_s_axis_tlast[p];
        sel_data   = bus.i_s_axis_tdata[8*p +: 8];
      end
    end
  end

  assign out_ready = !m_tvalid_q || bus.i_m_axis_tready;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gidx_d   = gidx_q;
    tready_c = '0;
    grant_c  = '0;
    busy_c   = 1'b0;
    accept   = 1'b0;
    next_rr  = 0;
    case (state_q)
      IDLE: begin
        if (scan_found) begin
          state_d = PKT;
          gidx_d  = scan_idx;
        end
      end
      PKT: begin
        busy_c   = 1'b1;
        grant_c  = gidx_oh;
        tready_c = out_ready ? gidx_oh : '0;
        accept   = sel_valid && out_ready;
        // Always fall back to IDLE after TLAST so there is one arbitration cycle.
        if (accept && sel_last) begin
          next_rr = int'(gidx_q) + 1;
          if (next_rr >= NPORTS) next_rr = 0;
          rr_d    = PTR_W'(next_rr);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else if (accept) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= sel_data;
      m_tkeep_q  <= sel_keep;
      m_tlast_q  <= sel_last;
    end else if (bus.i_m_axis_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign bus.o_s_axis_tready = tready_c;
  assign bus.o_grant         = grant_c;
  assign bus.o_busy          = busy_c;
  assign bus.o_m_axis_tvalid = m_tvalid_q;
  assign bus.o_m_axis_tdata  = m_tdata_q;
  assign bus.o_m_axis_tkeep  = m_tkeep_q;
  assign bus.o_m_axis_tlast  = m_tlast_q;
endmodule

// File: tb/tb_wbcon_txarb.sv
// Bench for wbcon_txarb: queued packet sources, random sink backpressure and a
// packet-level round-robin model that predicts the merged byte stream.
module tb_wbcon_txarb;
  localparam int NP = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       last;
  } beat_t;

  typedef struct packed {
    beat_t b;
    int    cyc;
  } out_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  wbcon_txarb_if #(.NPORTS(NP)) bus ();
  wbcon_txarb #(.NPORTS(NP)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  beat_t             src_q[NP][$];
  beat_t             mbeat[NP][$];
  int                mlen[NP][$];
  int                mcur[NP];
  bit                offer[NP];
  bit                first[NP];
  beat_t             exp_q[$];
  out_t              out_q[$];
  logic [NP-1:0]     grant_log[$];
  int                model_rr = 0;
  int                cyc = 0;
  int                errors = 0;
  int                checks = 0;
  int                bubble_pct = 0;
  bit                prev_stall = 1'b0;
  logic [10:0]       prev_out;
  logic              smp_tvalid, smp_busy;
  logic [7:0]        smp_tdata;
  logic [NP-1:0]     smp_sready, smp_grant;

  task automatic add_beat(input int p, input logic [7:0] d, input logic k, input logic l);
    beat_t b;
    b = '{data: d, keep: k, last: l};
    src_q[p].push_back(b);
    mbeat[p].push_back(b);
    mcur[p]++;
    if (l) begin
      mlen[p].push_back(mcur[p]);
      mcur[p] = 0;
    end
  endtask

  // Every queued packet is requesting whenever the arbiter is idle, so the
  // merged order is plain round-robin over whole packets.
  task automatic build_expected();
    bit found;
    int p, len;
    exp_q.delete();
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int i = 0; i < NP && !found; i++) begin
        p = (model_rr + i) % NP;
        if (mlen[p].size() > 0) begin
          len = mlen[p].pop_front();
          for (int j = 0; j < len; j++) exp_q.push_back(mbeat[p].pop_front());
          model_rr = (p + 1) % NP;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_logs();
    out_q.delete();
    grant_log.delete();
  endtask

  task automatic step(input bit rdy);
    logic [8*NP-1:0] td;
    logic [NP-1:0]   tv, tk, tl;
    bit              acc[NP];
    td = '0; tv = '0; tk = '0; tl = '0;
    for (int p = 0; p < NP; p++) begin
      acc[p] = 1'b0;
      if (src_q[p].size() > 0) begin
        if (!offer[p]) offer[p] = first[p] || ($urandom_range(99) >= bubble_pct);
        tv[p] = offer[p];
        td[8*p +: 8] = src_q[p][0].data;
        tk[p] = src_q[p][0].keep;
        tl[p] = src_q[p][0].last;
      end
    end
    bus.i_s_axis_tvalid = tv;
    bus.i_s_axis_tdata  = td;
    bus.i_s_axis_tkeep  = tk;
    bus.i_s_axis_tlast  = tl;
    bus.i_m_axis_tready = rdy;
    #1;
    smp_tvalid = bus.o_m_axis_tvalid;
    smp_tdata  = bus.o_m_axis_tdata;
    smp_sready = bus.o_s_axis_tready;
    smp_grant  = bus.o_grant;
    smp_busy   = bus.o_busy;
    grant_log.push_back(smp_grant);
    if (prev_stall) begin
      checks++;
      if ({bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tkeep, bus.o_m_axis_tlast} !== prev_out) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc,
                 {bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tkeep, bus.o_m_axis_tlast}, prev_out);
      end
    end
    checks++;
    if ((smp_sready & ~smp_grant) !== '0) begin
      errors++;
      $display("FAIL sready_outside_grant cyc=%0d sready=%b grant=%b", cyc, smp_sready, smp_grant);
    end
    prev_stall = smp_tvalid && !rdy;
    prev_out   = {bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tkeep, bus.o_m_axis_tlast};
    if (smp_tvalid && rdy)
      out_q.push_back('{b: '{data: bus.o_m_axis_tdata, keep: bus.o_m_axis_tkeep, last: bus.o_m_axis_tlast}, cyc: cyc});
    for (int p = 0; p < NP; p++) acc[p] = tv[p] && smp_sready[p];
    @(posedge i_clk);
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        first[p] = src_q[p][0].last;
        void'(src_q[p].pop_front());
        offer[p] = 1'b0;
      end
    end
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic run_drain(input int n_beats, input int sink_pct, input int max_cyc);
    int n = 0;
    while (out_q.size() < n_beats && n < max_cyc) begin
      step($urandom_range(99) < sink_pct);
      n++;
    end
    checks++;
    if (out_q.size() < n_beats) begin
      errors++;
      $display("FAIL drain_timeout got=%0d beats want=%0d", out_q.size(), n_beats);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    #1;
    checks++;
    if ({bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tkeep, bus.o_m_axis_tlast} !== 11'd0) begin
      errors++;
      $display("FAIL reset_m_axis got=%h want=0", {bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tkeep, bus.o_m_axis_tlast});
    end
    checks++;
    if ({bus.o_s_axis_tready, bus.o_grant, bus.o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_status got=%b want=0", {bus.o_s_axis_tready, bus.o_grant, bus.o_busy});
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    cyc++;
    clear_logs();
    step(1'b1);
    checks++;
    if ({smp_grant, smp_busy, smp_tvalid} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b want=0", {smp_grant, smp_busy, smp_tvalid});
    end
  endtask

  task automatic test_single_packet();
    int c0;
    clear_logs();
    add_beat(0, 8'h83, 1'b1, 1'b0);
    add_beat(0, 8'h11, 1'b1, 1'b0);
    add_beat(0, 8'h01, 1'b1, 1'b1);
    build_expected();
    c0 = cyc;
    run_drain(3, 100, 50);
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].b !== exp_q[i] || out_q[i].cyc !== c0 + 2 + i) begin
        errors++;
        $display("FAIL single_beat%0d got=%h@%0d want=%h@%0d", i, out_q[i].b, out_q[i].cyc - c0, exp_q[i], 2 + i);
      end
    end
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] !== ((i >= 1 && i <= 3) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL single_grant cyc+%0d got=%b want=%b", i, grant_log[i], (i >= 1 && i <= 3) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      add_beat(0, 8'h20 + 8'(2*k), 1'b1, 1'b0);
      add_beat(0, 8'h21 + 8'(2*k), 1'b1, 1'b1);
      add_beat(1, 8'h40 + 8'(2*k), 1'b1, 1'b0);
      add_beat(1, 8'h41 + 8'(2*k), 1'b1, 1'b1);
    end
    build_expected();
    run_drain(12, 100, 200);
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i].b !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got=%h want=%h", i, out_q[i].b, exp_q[i]);
      end
      if (i > 0) begin
        checks++;
        if (out_q[i].cyc - out_q[i-1].cyc !== (out_q[i-1].b.last ? 2 : 1)) begin
          errors++;
          $display("FAIL b2b_spacing beat%0d got=%0d want=%0d", i, out_q[i].cyc - out_q[i-1].cyc, out_q[i-1].b.last ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    add_beat(0, 8'h51, 1'b1, 1'b1);
    build_expected();
    run_drain(1, 100, 20);
    clear_logs();
    add_beat(0, 8'h52, 1'b1, 1'b1);
    build_expected();
    run_drain(1, 100, 20);
    checks++;
    if (grant_log.size() < 2 || grant_log[1] !== 2'b01 || out_q.size() < 1 || out_q[0].b.data !== 8'h52) begin
      errors++;
      $display("FAIL wrap_grant got=%b/%h want=01/52", grant_log.size() > 1 ? grant_log[1] : 2'bxx,
               out_q.size() > 0 ? out_q[0].b.data : 8'hxx);
    end
    // Port0 just finished, so port1 is ahead of port0 now.
    clear_logs();
    add_beat(0, 8'h53, 1'b1, 1'b1);
    add_beat(1, 8'h63, 1'b1, 1'b1);
    build_expected();
    run_drain(2, 100, 30);
    checks++;
    if (out_q.size() < 2 || out_q[0].b.data !== 8'h63 || out_q[1].b.data !== 8'h53) begin
      errors++;
      $display("FAIL wrap_order got=%h,%h want=63,53", out_q.size() > 0 ? out_q[0].b.data : 8'hxx,
               out_q.size() > 1 ? out_q[1].b.data : 8'hxx);
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i].b !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_beat%0d got=%h want=%h", i, out_q[i].b, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    clear_logs();
    add_beat(0, 8'hAA, 1'b1, 1'b0);
    add_beat(0, 8'h55, 1'b1, 1'b1);
    build_expected();
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      checks++;
      if (smp_tvalid !== 1'b1 || smp_tdata !== 8'hAA || smp_sready !== 2'b00) begin
        errors++;
        $display("FAIL stall_cycle%0d got v=%b d=%h rdy=%b want v=1 d=aa rdy=00", i, smp_tvalid, smp_tdata, smp_sready);
      end
    end
    run_drain(2, 100, 20);
    checks++;
    if (out_q.size() !== 2 || out_q[0].b !== exp_q[0] || out_q[1].b !== exp_q[1]) begin
      errors++;
      $display("FAIL stall_stream got n=%0d want n=2 aa,55", out_q.size());
    end
  endtask

  task automatic test_null_beat();
    clear_logs();
    add_beat(1, 8'h00, 1'b0, 1'b1);
    build_expected();
    run_drain(1, 100, 20);
    checks++;
    if (out_q.size() < 1 || out_q[0].b !== beat_t'{data: 8'h00, keep: 1'b0, last: 1'b1}) begin
      errors++;
      $display("FAIL null_beat got=%h want=001", out_q.size() > 0 ? out_q[0].b : 10'hx);
    end
    checks++;
    if (grant_log.size() < 3 || grant_log[1] !== 2'b10 || grant_log[2] !== 2'b00) begin
      errors++;
      $display("FAIL null_grant got=%b,%b want=10,00", grant_log.size() > 1 ? grant_log[1] : 2'bxx,
               grant_log.size() > 2 ? grant_log[2] : 2'bxx);
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_logs();
    add_beat(0, 8'h11, 1'b1, 1'b0);
    add_beat(0, 8'h22, 1'b1, 1'b0);
    add_beat(0, 8'h33, 1'b1, 1'b0);
    add_beat(0, 8'h44, 1'b1, 1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    #1;
    checks++;
    if (bus.o_m_axis_tvalid !== 1'b1 || bus.o_m_axis_tdata !== 8'h22) begin
      errors++;
      $display("FAIL midpkt_held got v=%b d=%h want v=1 d=22", bus.o_m_axis_tvalid, bus.o_m_axis_tdata);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tkeep, bus.o_m_axis_tlast,
         bus.o_s_axis_tready, bus.o_grant, bus.o_busy} !== '0) begin
      errors++;
      $display("FAIL midpkt_async_reset got=%h want=0", {bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tkeep,
               bus.o_m_axis_tlast, bus.o_s_axis_tready, bus.o_grant, bus.o_busy});
    end
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      mbeat[p].delete();
      mlen[p].delete();
      mcur[p]  = 0;
      offer[p] = 1'b0;
      first[p] = 1'b1;
    end
    model_rr   = 0;
    prev_stall = 1'b0;
    bus.i_s_axis_tvalid = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    cyc++;
    clear_logs();
    add_beat(0, 8'h71, 1'b1, 1'b0);
    add_beat(0, 8'h72, 1'b1, 1'b1);
    build_expected();
    run_drain(2, 100, 20);
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i].b !== exp_q[i]) begin
        errors++;
        $display("FAIL post_reset_beat%0d got=%h want=%h", i, out_q[i].b, exp_q[i]);
      end
    end
    checks++;
    if (grant_log.size() < 2 || grant_log[1] !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_grant got=%b want=01", grant_log.size() > 1 ? grant_log[1] : 2'bxx);
    end
  endtask

  task automatic test_random();
    int total = 0;
    int len;
    clear_logs();
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++) begin
        len = $urandom_range(5, 1);
        for (int j = 0; j < len; j++)
          add_beat(p, 8'($urandom), ($urandom_range(9) != 0), j == len - 1);
        total += len;
      end
    end
    build_expected();
    bubble_pct = 30;
    run_drain(total, 70, 3000);
    bubble_pct = 0;
    checks++;
    if (out_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_count got=%0d want=%0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i].b !== exp_q[i]) begin
        errors++;
        $display("FAIL random_beat%0d got=%h want=%h", i, out_q[i].b, exp_q[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_s_axis_tvalid = '0;
    bus.i_s_axis_tdata  = '0;
    bus.i_s_axis_tkeep  = '0;
    bus.i_s_axis_tlast  = '0;
    bus.i_m_axis_tready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      mcur[p]  = 0;
      offer[p] = 1'b0;
      first[p] = 1'b1;
    end
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_wrap();
    test_stall();
    test_null_beat();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
